atuador_robo: RTL and testbench
===============================

Name: atuador_robo

Overview:
- Downstream stage of the wall-following robot controller.
- Consumes the controller's level commands `avancar`, `girar` and `remover`, and turns each accepted command into a fixed-length, timed actuator action: wheel motors or removal arm.
- Tracks odometry (forward steps taken) and heading (quarter turns).
- Reports `ocupado`/`concluido` so the controller or the bench can pace commands.

Parameters:
- CNT_W, 8, width of the internal action-duration counter.
- STEP_CYCLES, 4, clock cycles a forward step lasts (1..2^CNT_W).
- TURN_CYCLES, 6, clock cycles a 90-degree turn lasts (1..2^CNT_W).
- REMOVE_CYCLES, 8, clock cycles an arm removal cycle lasts (1..2^CNT_W).
- POS_W, 8, width of the step odometer.

Ports:
- clock  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- avancar  input  1  command: one forward step.
- girar  input  1  command: one 90-degree rotation.
- remover  input  1  command: one barrier-removal cycle.
- motor_esq  output  1  left wheel drive enable.
- motor_dir  output  1  right wheel drive enable.
- reverso_dir  output  1  right wheel reverse (used while turning).
- braco  output  1  removal arm extend.
- ocupado  output  1  action in progress; commands ignored.
- concluido  output  1  one-cycle pulse on the last cycle of an action.
- erro  output  1  one-cycle pulse: more than one command high when sampled in OCIOSO.
- passos  output  POS_W  completed forward steps.
- rumo  output  2  heading, quarter turns modulo 4.

Behaviour:
- Interface:
  - One clock.
  - Reset is asynchronous and active-low.
  - Port names are `clock` and `reset`.
- Reset (`reset` = 0, immediate, any state including mid-action):
  - State OCIOSO; counter 0.
  - All outputs 0, including `passos` and `rumo`.
  - A partially executed action is discarded; it does not count in `passos` or `rumo`.
- All outputs are registered.
- State OCIOSO:
  - `ocupado`=0 and all actuator outputs 0.
  - On each rising edge, sample the commands with priority `remover` > `girar` > `avancar`:
    - `remover`=1: go to REMOVENDO, counter = REMOVE_CYCLES-1.
    - else `girar`=1: go to GIRANDO, counter = TURN_CYCLES-1.
    - else `avancar`=1: go to AVANCANDO, counter = STEP_CYCLES-1.
    - none: stay in OCIOSO.
  - If two or more commands are 1 at that edge, `erro`=1 for exactly the next cycle; the priority winner is still executed.
- Action states (outputs valid from the edge that entered the state):
  - AVANCANDO: `motor_esq`=1, `motor_dir`=1, `reverso_dir`=0, `braco`=0, `ocupado`=1.
  - GIRANDO: `motor_esq`=1, `motor_dir`=1, `reverso_dir`=1, `braco`=0, `ocupado`=1.
  - REMOVENDO: `braco`=1, all motor outputs 0, `ocupado`=1.
- Counting and completion:
  - Each cycle in an action state, the counter decrements.
  - When the counter = 0, `concluido`=1 for that cycle.
  - On the next edge: return to OCIOSO; `passos` += 1 (AVANCANDO only) or `rumo` += 1 mod 4 (GIRANDO only).
- Timing:
  - Each action keeps its outputs asserted for exactly N cycles (N = the matching *_CYCLES).
  - `ocupado` is high for exactly those N cycles.
  - Minimum one OCIOSO cycle between actions, so back-to-back commands give a period of N+1.
- Commands arriving while `ocupado`=1 are ignored, not queued; a level still held when OCIOSO is reached is accepted.
- Wrap-around:
  - `passos` wraps from 2^POS_W-1 to 0.
  - `rumo` wraps from 3 to 0.
- N=1: the action lasts one cycle, with `concluido` asserted in that cycle.

Optional Feature:
- Macro ATUADOR_PASSOS_SATURA_EN.
- Defined: `passos` saturates at 2^POS_W-1. A further completed step leaves it unchanged and pulses `erro` for one cycle, coincident with the cycle after `concluido`.
- Undefined: `passos` wraps modulo 2^POS_W; no `erro` on overflow.

Test Plan:
- Reset value and async reset: hold `reset`=0, apply clock → all outputs 0. Release, pulse `avancar` 1 cycle, drop `reset` to 0 at cycle 2 of the step (asynchronously, mid-clock) → outputs 0 immediately, `passos`=0.
- Single step: `avancar`=1 for 1 cycle with defaults → motors high 4 cycles, `concluido` on the 4th, then `passos`=1, `ocupado` low.
- Four turns: `girar` held high → 4 actions of 6 cycles each, separated by 1 OCIOSO cycle. `rumo` goes 1,2,3,0; `reverso_dir`=1 only during GIRANDO.
- Priority: `avancar`=`girar`=`remover`=1 in OCIOSO → REMOVENDO for 8 cycles with `braco`=1, `erro` pulse of 1 cycle; `passos` and `rumo` unchanged.
- Ignored commands: during AVANCANDO, pulse `girar` for 1 cycle (dropped before the step ends) → no turn occurs, `rumo` stays 0.
- Overflow with POS_W=2: 5 steps → `passos` goes 1,2,3,0,1 when the macro is undefined. When defined: `passos` goes 1,2,3,3,3, with `erro` pulses after steps 4 and 5.

Source files
------------

// File: rtl/atuador_robo.sv
// Actuator stage of the wall-following robot: turns level commands into timed
// wheel/arm actions and tracks step odometry and heading. Optional macro:
// ATUADOR_PASSOS_SATURA_EN makes `passos` saturate (with an `erro` pulse) instead of wrapping.
module atuador_robo #(
  parameter int CNT_W         = 8,
  parameter int STEP_CYCLES   = 4,
  parameter int TURN_CYCLES   = 6,
  parameter int REMOVE_CYCLES = 8,
  parameter int POS_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             avancar,
  input  logic             girar,
  input  logic             remover,
  output logic             motor_esq,
  output logic             motor_dir,
  output logic             reverso_dir,
  output logic             braco,
  output logic             ocupado,
  output logic             concluido,
  output logic             erro,
  output logic [POS_W-1:0] passos,
  output logic [1:0]       rumo
);

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    AVANCANDO = 2'd1,
    GIRANDO   = 2'd2,
    REMOVENDO = 2'd3
  } estado_t;

  localparam logic [CNT_W-1:0] STEP_INI   = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_INI   = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] REMOVE_INI = CNT_W'(REMOVE_CYCLES - 1);

  estado_t          estado, estado_prox;
  logic [CNT_W-1:0] cnt, cnt_prox;
  logic [POS_W-1:0] passos_prox;
  logic [1:0]       rumo_prox;
  logic             erro_prox;
  logic             multi;

  assign multi = (avancar & girar) | (avancar & remover) | (girar & remover);

  // Next state, counter, odometry/heading and error pulse
  always_comb begin
    estado_prox = estado;
    cnt_prox    = cnt;
    passos_prox = passos;
    rumo_prox   = rumo;
    erro_prox   = 1'b0;
    case (estado)
      OCIOSO: begin
        erro_prox = multi;
        if (remover) begin
          estado_prox = REMOVENDO;
          cnt_prox    = REMOVE_INI;
        end else if (girar) begin
          estado_prox = GIRANDO;
          cnt_prox    = TURN_INI;
        end else if (avancar) begin
          estado_prox = AVANCANDO;
          cnt_prox    = STEP_INI;
        end else begin
          estado_prox = OCIOSO;
        end
      end
      default: begin
        if (cnt == {CNT_W{1'b0}}) begin
          estado_prox = OCIOSO;
          // The completed action is credited on the edge that leaves it
          if (estado == AVANCANDO) begin
`ifdef ATUADOR_PASSOS_SATURA_EN
            if (passos == {POS_W{1'b1}}) begin
              erro_prox = 1'b1;
            end else begin
              passos_prox = passos + POS_W'(1);
            end
`else
            passos_prox = passos + POS_W'(1);
`endif
          end else if (estado == GIRANDO) begin
            rumo_prox = rumo + 2'd1;
          end else begin
            rumo_prox = rumo;
          end
        end else begin
          cnt_prox = cnt - CNT_W'(1);
        end
      end
    endcase
  end

  // State and registered outputs, derived from the upcoming state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado      <= OCIOSO;
      cnt         <= {CNT_W{1'b0}};
      motor_esq   <= 1'b0;
      motor_dir   <= 1'b0;
      reverso_dir <= 1'b0;
      braco       <= 1'b0;
      ocupado     <= 1'b0;
      concluido   <= 1'b0;
      erro        <= 1'b0;
      passos      <= {POS_W{1'b0}};
      rumo        <= 2'd0;
    end else begin
      estado      <= estado_prox;
      cnt         <= cnt_prox;
      motor_esq   <= (estado_prox == AVANCANDO) || (estado_prox == GIRANDO);
      motor_dir   <= (estado_prox == AVANCANDO) || (estado_prox == GIRANDO);
      reverso_dir <= (estado_prox == GIRANDO);
      braco       <= (estado_prox == REMOVENDO);
      ocupado     <= (estado_prox != OCIOSO);
      concluido   <= (estado_prox != OCIOSO) && (cnt_prox == {CNT_W{1'b0}});
      erro        <= erro_prox;
      passos      <= passos_prox;
      rumo        <= rumo_prox;
    end
  end

endmodule

// File: tb/tb_atuador_robo.sv
// Directed self-checking bench for atuador_robo (POS_W=2 so odometer overflow is reachable).
module tb_atuador_robo;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       avancar = 1'b0;
  logic       girar = 1'b0;
  logic       remover = 1'b0;
  logic       motor_esq, motor_dir, reverso_dir, braco, ocupado, concluido, erro;
  logic [1:0] passos;
  logic [1:0] rumo;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [4:0] ACT_PASSO = 5'b11001;  // {motor_esq,motor_dir,reverso_dir,braco,ocupado}
  localparam logic [4:0] ACT_GIRO  = 5'b11101;
  localparam logic [4:0] ACT_REMO  = 5'b00011;
  localparam logic [4:0] ACT_NADA  = 5'b00000;

  atuador_robo #(.POS_W(2)) dut (
    .clock(clock), .reset(reset), .avancar(avancar), .girar(girar), .remover(remover),
    .motor_esq(motor_esq), .motor_dir(motor_dir), .reverso_dir(reverso_dir), .braco(braco),
    .ocupado(ocupado), .concluido(concluido), .erro(erro), .passos(passos), .rumo(rumo)
  );

  always #5 clock = ~clock;

  wire [4:0] acts = {motor_esq, motor_dir, reverso_dir, braco, ocupado};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Walks through the n cycles of an action already entered
  task automatic run_action(input string tag, input logic [4:0] exp_act, input int n);
    for (int i = 1; i <= n; i++) begin
      chk({tag, "_act"}, 32'(acts), 32'(exp_act));
      chk({tag, "_concl"}, 32'(concluido), (i == n) ? 32'd1 : 32'd0);
      tick();
    end
  endtask

  initial begin
    // Reset held across clocks
    tick(); tick();
    chk("rst_act", 32'(acts), 32'(ACT_NADA));
    chk("rst_flags", 32'({concluido, erro}), 32'd0);
    chk("rst_passos", 32'(passos), 32'd0);
    chk("rst_rumo", 32'(rumo), 32'd0);

    // Asynchronous reset in the middle of a step
    reset = 1'b1;
    tick();
    avancar = 1'b1;
    tick();
    avancar = 1'b0;
    chk("ar_c1", 32'(acts), 32'(ACT_PASSO));
    tick();
    #2 reset = 1'b0;
    #1;
    chk("ar_act", 32'(acts), 32'(ACT_NADA));
    chk("ar_passos", 32'(passos), 32'd0);
    #1 reset = 1'b1;
    tick();
    chk("ar_idle", 32'(ocupado), 32'd0);

    // Single step
    avancar = 1'b1;
    tick();
    avancar = 1'b0;
    run_action("step", ACT_PASSO, 4);
    chk("step_idle", 32'(acts), 32'(ACT_NADA));
    chk("step_passos", 32'(passos), 32'd1);

    // Four turns with girar held
    girar = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      run_action("turn", ACT_GIRO, 6);
      chk("turn_gap", 32'(acts), 32'(ACT_NADA));
      chk("turn_rumo", 32'(rumo), 32'(k % 4));
      if (k == 4) girar = 1'b0;
      tick();
    end
    chk("turn_done", 32'(ocupado), 32'd0);
    chk("turn_passos", 32'(passos), 32'd1);

    // Priority: all three commands together
    {avancar, girar, remover} = 3'b111;
    tick();
    {avancar, girar, remover} = 3'b000;
    chk("prio_erro", 32'(erro), 32'd1);
    run_action("prio", ACT_REMO, 8);
    chk("prio_erro_off", 32'(erro), 32'd0);
    chk("prio_passos", 32'(passos), 32'd1);
    chk("prio_rumo", 32'(rumo), 32'd0);

    // Command during a step is ignored
    avancar = 1'b1;
    tick();
    avancar = 1'b0;
    tick();
    girar = 1'b1;
    tick();
    girar = 1'b0;
    chk("ign_c3", 32'(acts), 32'(ACT_PASSO));
    chk("ign_erro", 32'(erro), 32'd0);
    tick();
    chk("ign_concl", 32'(concluido), 32'd1);
    tick();
    chk("ign_passos", 32'(passos), 32'd2);
    tick();
    chk("ign_idle", 32'(acts), 32'(ACT_NADA));
    chk("ign_rumo", 32'(rumo), 32'd0);

    // Overflow of the 2-bit odometer
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("ovf_clear", 32'(passos), 32'd0);
    for (int s = 1; s <= 5; s++) begin
      avancar = 1'b1;
      tick();
      avancar = 1'b0;
      run_action("ovf", ACT_PASSO, 4);
`ifdef ATUADOR_PASSOS_SATURA_EN
      chk("ovf_passos", 32'(passos), (s > 3) ? 32'd3 : 32'(s));
      chk("ovf_erro", 32'(erro), (s > 3) ? 32'd1 : 32'd0);
`else
      chk("ovf_passos", 32'(passos), 32'(s % 4));
      chk("ovf_erro", 32'(erro), 32'd0);
`endif
      tick();
      chk("ovf_erro_gone", 32'(erro), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
